// File: rtl/aha_reset_req_sequencer.sv
// ============================================================================
// Module  : aha_reset_req_sequencer
// Brief   : Sequential 4-phase REQ/ACK reset requester with per-phase timeout.
//           Optional ACK 2-flop synchronizer: AHA_RST_SEQ_ACK_SYNC_EN.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module aha_reset_req_sequencer #(
    parameter int NUM_CH         = 8,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              CMD_VALID,
    input  logic [NUM_CH-1:0] CMD_MASK,
    output logic              CMD_READY,
    output logic [NUM_CH-1:0] REQ,
    input  logic [NUM_CH-1:0] ACK,
    output logic              BUSY,
    output logic              DONE,
    output logic [NUM_CH-1:0] ERR_MASK
);

    localparam int IW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] c_cnt_last = CW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_SCAN     = 3'd1,
        ST_WAIT_ACK = 3'd2,
        ST_WAIT_REL = 3'd3,
        ST_FIN      = 3'd4
    } state_t;

    state_t            r_state;
    logic [NUM_CH-1:0] r_pending;
    logic [NUM_CH-1:0] r_req;
    logic [NUM_CH-1:0] r_err_mask;
    logic [IW-1:0]     r_idx;
    logic [CW-1:0]     r_cnt;
    logic              r_done;

    logic [NUM_CH-1:0] w_ack_s;
    logic [IW-1:0]     w_lo_idx;
    logic [NUM_CH-1:0] w_lo_onehot;
    logic              w_ack_cur;
    logic              w_cnt_expired;

`ifdef AHA_RST_SEQ_ACK_SYNC_EN
    logic [NUM_CH-1:0] r_ack_meta;
    logic [NUM_CH-1:0] r_ack_sync;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_ack_meta <= '0;
            r_ack_sync <= '0;
        end else begin
            r_ack_meta <= ACK;
            r_ack_sync <= r_ack_meta;
        end
    end

    assign w_ack_s = r_ack_sync;
`else
    assign w_ack_s = ACK;
`endif

    // Lowest pending channel wins: scan from the top so the lowest index is written last.
    always_comb begin
        w_lo_idx = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (r_pending[i]) begin
                w_lo_idx = IW'(i);
            end
        end
    end

    assign w_lo_onehot   = NUM_CH'(1) << w_lo_idx;
    assign w_ack_cur     = w_ack_s[r_idx];
    assign w_cnt_expired = (r_cnt == c_cnt_last);

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_state    <= ST_IDLE;
            r_pending  <= '0;
            r_req      <= '0;
            r_err_mask <= '0;
            r_idx      <= '0;
            r_cnt      <= '0;
            r_done     <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (CMD_VALID) begin
                        r_pending  <= CMD_MASK;
                        r_err_mask <= '0;
                        if (CMD_MASK == '0) begin
                            r_state <= ST_FIN;
                            r_done  <= 1'b1;
                        end else begin
                            r_state <= ST_SCAN;
                        end
                    end
                end
                ST_SCAN: begin
                    r_idx     <= w_lo_idx;
                    r_pending <= r_pending & ~w_lo_onehot;
                    r_req     <= w_lo_onehot;
                    r_cnt     <= '0;
                    r_state   <= ST_WAIT_ACK;
                end
                ST_WAIT_ACK: begin
                    if (w_ack_cur || w_cnt_expired) begin
                        if (!w_ack_cur) begin
                            r_err_mask[r_idx] <= 1'b1;
                        end
                        r_req   <= '0;
                        r_cnt   <= '0;
                        r_state <= ST_WAIT_REL;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                ST_WAIT_REL: begin
                    // A release seen on the last allowed cycle still counts as clean.
                    if (!w_ack_cur || w_cnt_expired) begin
                        if (w_ack_cur) begin
                            r_err_mask[r_idx] <= 1'b1;
                        end
                        if (r_pending != '0) begin
                            r_state <= ST_SCAN;
                        end else begin
                            r_state <= ST_FIN;
                            r_done  <= 1'b1;
                        end
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                ST_FIN: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign CMD_READY = (r_state == ST_IDLE);
    assign BUSY      = (r_state != ST_IDLE);
    assign REQ       = r_req;
    assign DONE      = r_done;
    assign ERR_MASK  = r_err_mask;

endmodule

`default_nettype wire

// File: tb/tb_aha_reset_req_sequencer.sv
// ============================================================================
// Module  : tb_aha_reset_req_sequencer
// Brief   : Randomized bench for aha_reset_req_sequencer with a cycle-cost model.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_aha_reset_req_sequencer;

    localparam int NCH = 8;
    localparam int TO  = 16;
`ifdef AHA_RST_SEQ_ACK_SYNC_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 0;
`endif

    localparam int B_NORMAL = 0;
    localparam int B_NEVER  = 1;
    localparam int B_STUCK  = 2;

    logic           CLK = 1'b0;
    logic           RESET;
    logic           CMD_VALID;
    logic [NCH-1:0] CMD_MASK;
    logic           CMD_READY;
    logic [NCH-1:0] REQ;
    logic [NCH-1:0] ACK;
    logic           BUSY;
    logic           DONE;
    logic [NCH-1:0] ERR_MASK;

    int n_vec = 0;
    int n_err = 0;

    int beh [NCH];
    int d1  [NCH];
    int d2  [NCH];

    aha_reset_req_sequencer #(
        .NUM_CH         (NCH),
        .TIMEOUT_CYCLES (TO)
    ) u_dut (
        .CLK       (CLK),
        .RESET     (RESET),
        .CMD_VALID (CMD_VALID),
        .CMD_MASK  (CMD_MASK),
        .CMD_READY (CMD_READY),
        .REQ       (REQ),
        .ACK       (ACK),
        .BUSY      (BUSY),
        .DONE      (DONE),
        .ERR_MASK  (ERR_MASK)
    );

    always #5 CLK = ~CLK;

    task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed %0d (0x%0h) expected %0d (0x%0h)", tag, obs, obs, exp, exp);
        end
    endtask

    function automatic int first_set(input logic [NCH-1:0] v);
        for (int i = 0; i < NCH; i++) begin
            if (v[i]) return i;
        end
        return -1;
    endfunction

    // Each selected channel costs SCAN + REQ-high time + release time, in mask order.
    task automatic run_cmd(input logic [NCH-1:0] mask, input bit inject);
        int             exp_ch[$];
        int             exp_len[$];
        int             got_ch[$];
        int             got_len[$];
        int             sum;
        int             h;
        int             r;
        logic [NCH-1:0] exp_err;
        logic [NCH-1:0] err_at_done;
        int             hi[NCH];
        int             lo[NCH];
        int             ph[NCH];
        int             cur_ch;
        int             cur_len;
        int             ch;
        int             k_done;
        int             n_done;
        int             busy_cnt;
        int             multi;
        int             n_cmp;

        sum     = 0;
        exp_err = '0;
        for (int c = 0; c < NCH; c++) begin
            hi[c] = 0;
            lo[c] = 0;
            ph[c] = 0;
            ACK[c] = 1'b0;
            if (mask[c]) begin
                case (beh[c])
                    B_NEVER: begin h = TO;          r = 1;          exp_err[c] = 1'b1; end
                    B_STUCK: begin h = 1;           r = TO;         exp_err[c] = 1'b1; ACK[c] = 1'b1; end
                    default: begin h = d1[c] + LAT; r = d2[c] + LAT; end
                endcase
                exp_ch.push_back(c);
                exp_len.push_back(h);
                sum += 1 + h + r;
            end
        end

        repeat (4) @(negedge CLK);
        check_value("ready_before_cmd", {31'd0, CMD_READY}, 32'd1);
        CMD_VALID = 1'b1;
        CMD_MASK  = mask;
        @(negedge CLK);
        CMD_VALID = 1'b0;
        CMD_MASK  = NCH'($urandom);

        cur_ch = -1; cur_len = 0; k_done = 0; n_done = 0; busy_cnt = 0; multi = 0;
        err_at_done = '0;
        for (int k = 1; k <= sum + 4; k++) begin
            if (k > 1) @(negedge CLK);
            if ($countones(REQ) > 1) multi++;
            if (REQ != '0) begin
                ch = first_set(REQ);
                if (ch == cur_ch) begin
                    cur_len++;
                end else begin
                    if (cur_ch >= 0) begin got_ch.push_back(cur_ch); got_len.push_back(cur_len); end
                    cur_ch  = ch;
                    cur_len = 1;
                end
            end else if (cur_ch >= 0) begin
                got_ch.push_back(cur_ch);
                got_len.push_back(cur_len);
                cur_ch = -1;
            end
            if (DONE) begin
                n_done++;
                if (k_done == 0) begin
                    k_done      = k;
                    err_at_done = ERR_MASK;
                end
            end
            if (BUSY) busy_cnt++;

            for (int c = 0; c < NCH; c++) begin
                if (mask[c] && beh[c] == B_NORMAL) begin
                    if (ph[c] == 0 && REQ[c]) begin
                        hi[c]++;
                        if (hi[c] == d1[c]) begin ACK[c] = 1'b1; ph[c] = 1; end
                    end else if (ph[c] == 1 && !REQ[c]) begin
                        lo[c]++;
                        if (lo[c] == d2[c]) begin ACK[c] = 1'b0; ph[c] = 2; end
                    end
                end
            end

            if (inject && mask != '0) begin
                if (k == 3) begin CMD_VALID = 1'b1; CMD_MASK = NCH'($urandom) | 8'h01; end
                if (k == 4) CMD_VALID = 1'b0;
            end
        end
        if (cur_ch >= 0) begin got_ch.push_back(cur_ch); got_len.push_back(cur_len); end
        ACK = '0;

        check_value("done_cycle", k_done, sum + 1);
        check_value("done_count", n_done, 1);
        check_value("busy_cycles", busy_cnt, sum + 1);
        check_value("err_at_done", {24'd0, err_at_done}, {24'd0, exp_err});
        check_value("err_held", {24'd0, ERR_MASK}, {24'd0, exp_err});
        check_value("req_onehot_violations", multi, 0);
        check_value("req_pulse_count", got_ch.size(), exp_ch.size());
        n_cmp = (got_ch.size() < exp_ch.size()) ? got_ch.size() : exp_ch.size();
        for (int i = 0; i < n_cmp; i++) begin
            check_value("req_pulse_channel", got_ch[i], exp_ch[i]);
            check_value("req_pulse_length", got_len[i], exp_len[i]);
        end
    endtask

    task automatic set_normal(input int c, input int a, input int b);
        beh[c] = B_NORMAL;
        d1[c]  = a;
        d2[c]  = b;
    endtask

    initial begin
        int k_rst;
        int n_done_after;
        int req_after;

        RESET     = 1'b1;
        CMD_VALID = 1'b0;
        CMD_MASK  = '0;
        ACK       = '0;
        for (int c = 0; c < NCH; c++) set_normal(c, 1, 1);
        repeat (3) @(negedge CLK);
        check_value("rst_req", {24'd0, REQ}, 32'd0);
        check_value("rst_done", {31'd0, DONE}, 32'd0);
        check_value("rst_busy", {31'd0, BUSY}, 32'd0);
        check_value("rst_ready", {31'd0, CMD_READY}, 32'd1);
        check_value("rst_err", {24'd0, ERR_MASK}, 32'd0);
        RESET = 1'b0;

        set_normal(2, 5, 3);
        run_cmd(8'h04, 1'b0);
        set_normal(0, 2, 4);
        set_normal(7, 3, 2);
        run_cmd(8'h81, 1'b0);
        run_cmd(8'h00, 1'b0);
        beh[0] = B_NEVER;
        set_normal(1, 4, 4);
        run_cmd(8'h03, 1'b0);
        beh[3] = B_STUCK;
        run_cmd(8'h08, 1'b0);
        set_normal(5, TO - LAT, TO - LAT);
        run_cmd(8'h20, 1'b1);

        for (int n = 0; n < 40; n++) begin
            logic [NCH-1:0] m;
            int             sel;
            for (int c = 0; c < NCH; c++) begin
                sel = $urandom_range(0, 9);
                if (sel < 6)      set_normal(c, $urandom_range(1, TO - LAT), $urandom_range(1, TO - LAT));
                else if (sel < 8) beh[c] = B_NEVER;
                else              beh[c] = B_STUCK;
            end
            m = NCH'($urandom);
            if ($urandom_range(0, 7) == 0) m = '0;
            run_cmd(m, 1'($urandom_range(0, 1)));
        end

        // Reset while channel 1 is waiting for its ACK, after channel 0 has already timed out.
        beh[0] = B_NEVER;
        beh[1] = B_NEVER;
        ACK    = '0;
        repeat (4) @(negedge CLK);
        CMD_VALID = 1'b1;
        CMD_MASK  = 8'h03;
        @(negedge CLK);
        CMD_VALID = 1'b0;
        k_rst = 1 + (1 + TO + 1) + 1 + 4;
        repeat (k_rst - 1) @(negedge CLK);
        check_value("pre_rst_req", {24'd0, REQ}, 32'h02);
        check_value("pre_rst_err", {24'd0, ERR_MASK}, 32'h01);
        CMD_VALID = 1'b1;
        CMD_MASK  = 8'h10;
        @(negedge CLK);
        CMD_VALID = 1'b0;
        check_value("busy_cmd_ignored_req", {24'd0, REQ}, 32'h02);
        RESET = 1'b1;
        @(negedge CLK);
        RESET = 1'b0;
        check_value("mid_rst_req", {24'd0, REQ}, 32'd0);
        check_value("mid_rst_ready", {31'd0, CMD_READY}, 32'd1);
        check_value("mid_rst_err", {24'd0, ERR_MASK}, 32'd0);
        check_value("mid_rst_done", {31'd0, DONE}, 32'd0);
        n_done_after = 0;
        req_after    = 0;
        repeat (20) begin
            @(negedge CLK);
            if (DONE) n_done_after++;
            if (REQ != '0) req_after++;
        end
        check_value("post_rst_done_pulses", n_done_after, 0);
        check_value("post_rst_req_cycles", req_after, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
